// File: rtl/student_tlul_arbiter_if.sv
// TL-UL channel types and the bundled port interface of student_tlul_arbiter.
// The master modport is the arbiter's view; the slave modport is the side
// that drives host requests and device responses into it.
package tlul_pkg;

  // Host-to-device: A-channel request plus the host's D-channel ready.
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  // Device-to-host: D-channel response plus the device's A-channel ready.
  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

interface student_tlul_arbiter_if #(
  parameter int NUM = 2
);
  tlul_pkg::tl_h2d_t tl_host_i [NUM];
  tlul_pkg::tl_d2h_t tl_host_o [NUM];
  tlul_pkg::tl_h2d_t tl_device_o;
  tlul_pkg::tl_d2h_t tl_device_i;

  modport master (
    input  tl_host_i,
    input  tl_device_i,
    output tl_host_o,
    output tl_device_o
  );

  modport slave (
    output tl_host_i,
    output tl_device_i,
    input  tl_host_o,
    input  tl_device_o
  );
endinterface

// File: rtl/student_tlul_arbiter.sv
// N-to-1 TL-UL arbiter: round-robin grant of one host at a time, exactly one
// outstanding transaction, response routed back to the issuing host.
module student_tlul_arbiter #(
  parameter int NUM = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  student_tlul_arbiter_if.master tl
);
  import tlul_pkg::*;

  localparam int GW = (NUM > 1) ? $clog2(NUM) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] prio_q, prio_d;

  tl_h2d_t       sel_host;
  logic          pick_found;
  logic [GW-1:0] pick_idx;

  // Request of the granted host, decoded from grant with constant indices only.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    sel_host = '0;
    for (int k = 0; k < NUM; k++) begin
      if (GW'(k) == grant_q) sel_host = tl.tl_host_i[k];
    end
  end

  // Round-robin search: first host with a_valid at prio, prio+1, ... (mod NUM).
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM; i++) begin
      for (int k = 0; k < NUM; k++) begin
        if (!pick_found && (k == (int'(prio_q) + i) % NUM) && tl.tl_host_i[k].a_valid) begin
          pick_found = 1'b1;
          pick_idx   = GW'(k);
        end
      end
    end
  end

  // Next state: IDLE -> REQ on a grant, REQ -> RESP on the A handshake,
  // RESP -> IDLE on the D handshake with prio moved past the served host.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        if (sel_host.a_valid && tl.tl_device_i.a_ready) state_d = RESP;
      end
      RESP: begin
        if (tl.tl_device_i.d_valid && sel_host.d_ready) begin
          prio_d  = GW'((int'(grant_q) + 1) % NUM);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; a synchronous reset drops any in-flight transaction.
  always_ff @(posedge clk_i) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

  // Output steering: only the granted host and the device see non-zero values,
  // and nothing from the hosts reaches an output while idle.
  always_comb begin
    tl.tl_device_o = '0;
    for (int k = 0; k < NUM; k++) begin
      tl.tl_host_o[k] = '0;
    end
    unique case (state_q)
      REQ: begin
        tl.tl_device_o         = sel_host;
        tl.tl_device_o.d_ready = 1'b0;
        for (int k = 0; k < NUM; k++) begin
          if (GW'(k) == grant_q) tl.tl_host_o[k].a_ready = tl.tl_device_i.a_ready;
        end
      end
      RESP: begin
        tl.tl_device_o.d_ready = sel_host.d_ready;
        for (int k = 0; k < NUM; k++) begin
          if (GW'(k) == grant_q) begin
            tl.tl_host_o[k]         = tl.tl_device_i;
            tl.tl_host_o[k].a_ready = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
